// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the parametrised instruction memory.
package instr_mem_pkg;

   typedef enum logic {
      INIT,
      IDLE
   } state_t;

   localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

   function automatic logic [31:0] word_index(input logic [31:0] address);
      return address >> 2;
   endfunction

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x XLEN storage: one byte-enabled write port, one registered read-first read port.
module instr_mem_array #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 32,
   parameter int PTR_W = 5
) (
   input  logic                clk,
   input  logic                we,
   input  logic [PTR_W-1:0]    waddr,
   input  logic [XLEN/8-1:0]   wen,
   input  logic [XLEN-1:0]     wdata,
   input  logic                re,
   input  logic [PTR_W-1:0]    raddr,
   output logic [XLEN-1:0]     rdata
);

   logic [XLEN-1:0] mem [DEPTH];

   // Non-blocking read and write in one block give old data on a same-address collision.
   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[raddr];
      end
      if (we) begin
         for (int i = 0; i < XLEN/8; i++) begin
            if (wen[i]) begin
               mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/instr_mem_param.sv
// Writable instruction memory: NOP fill after reset, then byte-enabled writes and
// one-cycle registered reads with alignment/range fault reporting.
module instr_mem_param
   import instr_mem_pkg::*;
#(
   parameter int               XLEN     = 32,
   parameter int               DEPTH    = 32,
   parameter int               ADDR_W   = 7,
   parameter logic [XLEN-1:0]  NOP_WORD = XLEN'(NOP_DEFAULT)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                mem_read,
   input  logic                mem_write,
   input  logic [ADDR_W-1:0]   address,
   input  logic [XLEN-1:0]     imem_in,
   input  logic [XLEN/8-1:0]   wstrb,
   output logic                ready,
   output logic [XLEN-1:0]     imem_out,
   output logic                imem_valid,
   output logic                fault,
   output logic                init_done
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t             state, state_next;
   logic [PTR_W-1:0]   fill_ptr, fill_next;
   logic [31:0]        widx;
   logic [PTR_W-1:0]   word_ptr;
   logic               misaligned, out_of_range, bad, accept;
   logic               we, re;
   logic [PTR_W-1:0]   waddr;
   logic [XLEN-1:0]    wdata, rd_data;
   logic [XLEN/8-1:0]  wen;
   logic               valid_q, fault_q;

   always_comb widx = word_index(32'(address));

   assign word_ptr     = widx[PTR_W-1:0];
   assign misaligned   = (address[1:0] != 2'b00);
   assign out_of_range = (widx >= 32'(DEPTH));
   assign bad          = misaligned | out_of_range;
   assign accept       = (state == IDLE) & (mem_read | mem_write);

   // INIT owns the write port to lay down NOPs; IDLE hands it to accepted good writes.
   always_comb begin
      state_next = state;
      fill_next  = fill_ptr;
      we         = 1'b0;
      re         = 1'b0;
      waddr      = word_ptr;
      wdata      = imem_in;
      wen        = wstrb;
      unique case (state)
         INIT: begin
            we    = 1'b1;
            waddr = fill_ptr;
            wdata = NOP_WORD;
            wen   = '1;
            if (fill_ptr == PTR_W'(DEPTH - 1)) begin
               state_next = IDLE;
               fill_next  = '0;
            end else begin
               fill_next = fill_ptr + PTR_W'(1);
            end
         end
         IDLE: begin
            we = accept & mem_write & ~bad;
            re = accept & mem_read & ~bad;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= INIT;
         fill_ptr <= '0;
         valid_q  <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state    <= state_next;
         fill_ptr <= fill_next;
         valid_q  <= accept & mem_read;
         fault_q  <= accept & bad;
      end
   end

   instr_mem_array #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_array (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wen   (wen),
      .wdata (wdata),
      .re    (re),
      .raddr (word_ptr),
      .rdata (rd_data)
   );

   // Stale array data is masked so imem_out is zero outside good read responses.
   assign imem_out   = (valid_q & ~fault_q) ? rd_data : '0;
   assign imem_valid = valid_q;
   assign fault      = fault_q;
   assign ready      = (state == IDLE);
   assign init_done  = (state == IDLE);

endmodule

// File: tb/tb_instr_mem_param.sv
// Scoreboard bench: two instances (DEPTH 32 and 16) share stimulus; a cycle-level
// memory model predicts responses, a negedge monitor pops and compares them.
module tb_instr_mem_param;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      int          due;
      logic        valid;
      logic        fault;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_read, mem_write;
   logic [6:0]  address;
   logic [31:0] imem_in;
   logic [3:0]  wstrb;

   logic        ready32, valid32, fault32, done32;
   logic [31:0] out32;
   logic        ready16, valid16, fault16, done16;
   logic [31:0] out16;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   bit          started  = 1'b0;

   exp_t        q0[$];
   exp_t        q1[$];
   logic [31:0] mm[2][32];
   bit          rdy_m[2];
   int          fill_cnt[2];

   always #5 clk = ~clk;

   instr_mem_param dut32 (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
      .address(address), .imem_in(imem_in), .wstrb(wstrb), .ready(ready32),
      .imem_out(out32), .imem_valid(valid32), .fault(fault32), .init_done(done32)
   );

   instr_mem_param #(.DEPTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
      .address(address), .imem_in(imem_in), .wstrb(wstrb), .ready(ready16),
      .imem_out(out16), .imem_valid(valid16), .fault(fault16), .init_done(done16)
   );

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, cyc, act, exp);
      end
   endtask

   task automatic note_fail(input string name, input int d);
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s dut%0d cycle %0d", name, d, cyc);
   endtask

   function automatic bit q_peek(input int d, output exp_t e);
      if (d == 0) begin
         if (q0.size() == 0) return 1'b0;
         e = q0[0];
      end else begin
         if (q1.size() == 0) return 1'b0;
         e = q1[0];
      end
      return 1'b1;
   endfunction

   task automatic q_pop(input int d);
      if (d == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
   endtask

   task automatic q_push(input int d, input exp_t e);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // Reference model: memory is an array of words, readiness is a count of clean cycles.
   always @(posedge clk) begin
      int   dep, idx;
      bit   bad;
      exp_t e;
      cyc++;
      if (!rst_n) started = 1'b1;
      for (int d = 0; d < 2; d++) begin
         dep = (d == 0) ? 32 : 16;
         if (!rst_n) begin
            rdy_m[d]    = 1'b0;
            fill_cnt[d] = 0;
         end else if (!rdy_m[d]) begin
            fill_cnt[d]++;
            if (fill_cnt[d] == dep) begin
               rdy_m[d] = 1'b1;
               for (int k = 0; k < 32; k++) mm[d][k] = NOP;
            end
         end else if (mem_read || mem_write) begin
            idx     = int'(address) / 4;
            bad     = (int'(address) % 4 != 0) || (idx >= dep);
            e.due   = cyc;
            e.valid = mem_read;
            e.fault = bad;
            e.data  = (mem_read && !bad) ? mm[d][idx] : 32'h0;
            if (mem_read || bad) q_push(d, e);
            if (mem_write && !bad) begin
               for (int b = 0; b < 4; b++)
                  if (wstrb[b]) mm[d][idx][8*b +: 8] = imem_in[8*b +: 8];
            end
         end
      end
   end

   task automatic check_output(input int d, input logic rdy, input logic idn,
                               input logic vld, input logic flt, input logic [31:0] dout);
      exp_t e;
      if (!started) return;
      chk("ready", d, 32'(rdy), 32'(rdy_m[d]));
      chk("init_done", d, 32'(idn), 32'(rdy_m[d]));
      while (q_peek(d, e) && e.due < cyc) begin
         note_fail("missing_response", d);
         q_pop(d);
      end
      if (vld || flt) begin
         if (q_peek(d, e) && e.due == cyc) begin
            chk("imem_valid", d, 32'(vld), 32'(e.valid));
            chk("fault", d, 32'(flt), 32'(e.fault));
            chk("imem_out", d, dout, e.data);
            q_pop(d);
         end else begin
            note_fail("unexpected_response", d);
         end
      end else begin
         chk("idle_imem_out", d, dout, 32'h0);
         if (q_peek(d, e) && e.due == cyc) begin
            note_fail("missing_response", d);
            q_pop(d);
         end
      end
   endtask

   always @(negedge clk) begin
      check_output(0, ready32, done32, valid32, fault32, out32);
      check_output(1, ready16, done16, valid16, fault16, out16);
   end

   task automatic apply_stimulus(input bit rd, input bit wr, input logic [6:0] a,
                                 input logic [31:0] dat, input logic [3:0] s);
      mem_read  = rd;
      mem_write = wr;
      address   = a;
      imem_in   = dat;
      wstrb     = s;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 100; i++) begin
         if (ready32 && ready16) return;
         apply_stimulus(0, 0, 7'h00, 32'h0, 4'h0);
      end
      note_fail("init_timeout", 0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [6:0] a;
      rst_n = 1'b0;
      repeat (3) apply_stimulus(0, 0, 7'h00, 32'h0, 4'h0);
      rst_n = 1'b1;
      repeat (5) apply_stimulus(0, 0, 7'h00, 32'h0, 4'h0);
      apply_stimulus(1, 0, 7'h00, 32'h0, 4'h0);
      wait_ready();

      apply_stimulus(1, 0, 7'h00, 32'h0, 4'h0);
      apply_stimulus(0, 1, 7'h04, 32'h0070_0813, 4'b1111);
      apply_stimulus(1, 0, 7'h04, 32'h0, 4'h0);
      apply_stimulus(0, 1, 7'h04, 32'hAABB_CCDD, 4'b0010);
      apply_stimulus(1, 0, 7'h04, 32'h0, 4'h0);
      apply_stimulus(1, 1, 7'h08, 32'h1234_5678, 4'b1111);
      apply_stimulus(1, 0, 7'h08, 32'h0, 4'h0);
      apply_stimulus(1, 0, 7'h06, 32'h0, 4'h0);
      apply_stimulus(0, 1, 7'h40, 32'hFFFF_FFFF, 4'b1111);
      apply_stimulus(1, 0, 7'h40, 32'h0, 4'h0);
      apply_stimulus(1, 0, 7'h00, 32'h0, 4'h0);
      apply_stimulus(1, 0, 7'h7C, 32'h0, 4'h0);

      apply_stimulus(0, 1, 7'h0C, 32'hDEAD_BEEF, 4'b1111);
      rst_n = 1'b0;
      apply_stimulus(0, 0, 7'h00, 32'h0, 4'h0);
      rst_n = 1'b1;
      wait_ready();
      apply_stimulus(1, 0, 7'h0C, 32'h0, 4'h0);

      for (int i = 0; i < 600; i++) begin
         a = 7'($urandom_range(0, 127));
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         rst_n = ($urandom_range(0, 149) != 0);
         apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                        $urandom, 4'($urandom_range(0, 15)));
      end
      rst_n = 1'b1;
      repeat (3) apply_stimulus(0, 0, 7'h00, 32'h0, 4'h0);

      chk("scoreboard_drained", 0, 32'(q0.size()), 32'h0);
      chk("scoreboard_drained", 1, 32'(q1.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
